// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Desc    : Shared types and helpers for the multi-port register file.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    function automatic int calc_aw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clr_seq.sv
// ============================================================================
// Module  : regfile_clr_seq
// Desc    : Clear sequencer; walks registers 1..NREGS-1 writing zero.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    localparam int AW   = calc_aw(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = AW'(1);
                end
            end
            CLEAR: begin
                // cnt wraps to 0 on the final step; its value is unused in IDLE
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy && !rst;
    assign clr_addr = cnt_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module  : regfile_mp
// Desc    : NRD-read / 2-write register file, hardwired x0, optional bypass.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                clr_req,
    output logic                busy
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_ok, w0_en, w1_en;

    // Entry 0 is not stored; x0 is produced by the read muxes.
    logic [XLEN-1:0] mem_q [1:NREGS-1];

    regfile_clr_seq #(
        .NREGS    (NREGS)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_ok = !busy && !rst;
    assign w0_en = we0 && wr_ok;
    assign w1_en = we1 && wr_ok;

    // Port 1 is tested first so it wins an address collision.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (clr_we && clr_addr == AW'(i)) begin
                mem_q[i] <= '0;
            end else if (w1_en && wa1 == AW'(i)) begin
                mem_q[i] <= wd1;
            end else if (w0_en && wa0 == AW'(i)) begin
                mem_q[i] <= wd0;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra_k;
        logic [XLEN-1:0] rd_k;

        assign ra_k = ra[k*AW +: AW];

        always_comb begin
            rd_k = '0;
            if (!busy && ra_k != '0) begin
                rd_k = mem_q[ra_k];
                if (BYPASS != 0) begin
                    if (w1_en && wa1 == ra_k) begin
                        rd_k = wd1;
                    end else if (w0_en && wa0 == ra_k) begin
                        rd_k = wd0;
                    end
                end
            end
        end

        assign rd[k*XLEN +: XLEN] = rd_k;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module  : tb_regfile_mp
// Desc    : Scoreboard bench; bypass and non-bypass instances share stimulus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0]       wa0 = '0, wa1 = '0;
    logic [XLEN-1:0]     wd0 = '0, wd1 = '0;
    logic [NRD*AW-1:0]   ra  = '0;
    logic                clr_req = 1'b0;
    logic [NRD*XLEN-1:0] rd_b, rd_n;
    logic                busy_b, busy_n;

    typedef struct {
        int          src;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [0:NREGS-1];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rd(rd_b),
        .clr_req(clr_req), .busy(busy_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rd(rd_n),
        .clr_req(clr_req), .busy(busy_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // src: 0/1 = bypass rd port0/1, 2/3 = no-bypass rd port0/1, 4/5 = busy
    function automatic logic [31:0] observe(input int src);
        case (src)
            0:       return rd_b[31:0];
            1:       return rd_b[63:32];
            2:       return rd_n[31:0];
            3:       return rd_n[63:32];
            4:       return {31'b0, busy_b};
            default: return {31'b0, busy_n};
        endcase
    endfunction

    task automatic push(input int src, input logic [31:0] exp, input string tag);
        exp_t e;
        e.src = src;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.src), e.exp);
        end
    endtask

    task automatic set_ra(input int a0, input int a1);
        ra = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle_inputs();
        we0 = 1'b0;
        we1 = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            set_ra(i, NREGS - 1 - i);
            push(0, model[i], $sformatf("%s_b0_r%0d", tag, i));
            push(1, model[NREGS-1-i], $sformatf("%s_b1_r%0d", tag, NREGS - 1 - i));
            push(2, model[i], $sformatf("%s_n0_r%0d", tag, i));
            push(3, model[NREGS-1-i], $sformatf("%s_n1_r%0d", tag, NREGS - 1 - i));
            drain();
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 1; i < NREGS; i++) begin
            @(negedge clk);
            we0 = 1'b1;
            wa0 = AW'(i);
            wd0 = base ^ 32'(i);
            model[i] = base ^ 32'(i);
        end
        @(negedge clk);
        we0 = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        zero_model();

        // Reset: hold 3 cycles
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        set_ra(3, 9);
        push(4, 32'd1, "rst_busy_b");
        push(5, 32'd1, "rst_busy_n");
        push(0, 32'd0, "rst_rd0");
        push(1, 32'd0, "rst_rd1");
        drain();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n = 0;
        while (busy_b && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check_eq("rst_busy_len", 32'(n), 32'd31);
        push(5, 32'd0, "rst_busy_n_done");
        drain();
        read_all("rst");

        // Dual write collision on reg5
        @(negedge clk);
        we0 = 1'b1; wa0 = 5; wd0 = 32'hAAAA_0000;
        we1 = 1'b1; wa1 = 5; wd1 = 32'h1234_5678;
        set_ra(5, 0);
        push(0, 32'h1234_5678, "coll_byp");
        push(2, 32'h0000_0000, "coll_nobyp_old");
        push(1, 32'h0000_0000, "coll_x0");
        drain();
        model[5] = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        push(0, model[5], "coll_b_next");
        push(2, model[5], "coll_n_next");
        drain();

        // x0 protection
        @(negedge clk);
        we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 0; wd1 = 32'hFFFF_FFFF;
        set_ra(0, 0);
        push(0, 32'd0, "x0_same_b0");
        push(1, 32'd0, "x0_same_b1");
        push(2, 32'd0, "x0_same_n0");
        drain();
        @(negedge clk);
        idle_inputs();
        push(0, 32'd0, "x0_after_b0");
        push(3, 32'd0, "x0_after_n1");
        drain();

        // Bypass vs no bypass on reg7, plus independent port-1 write to reg9
        @(negedge clk);
        we0 = 1'b1; wa0 = 7; wd0 = 32'hDEAD_BEEF;
        we1 = 1'b1; wa1 = 9; wd1 = 32'hCAFE_0009;
        set_ra(7, 9);
        push(0, 32'hDEAD_BEEF, "byp_same_b0");
        push(1, 32'hCAFE_0009, "byp_same_b1");
        push(2, model[7], "byp_same_n0");
        push(3, model[9], "byp_same_n1");
        drain();
        model[7] = 32'hDEAD_BEEF;
        model[9] = 32'hCAFE_0009;
        @(negedge clk);
        idle_inputs();
        push(0, model[7], "byp_next_b0");
        push(2, model[7], "byp_next_n0");
        push(3, model[9], "byp_next_n1");
        drain();

        // Runtime clear with dropped write and ignored re-request
        fill(32'h0);
        @(negedge clk);
        set_ra(3, 31);
        push(0, 32'd3, "fill_r3");
        push(3, 32'd31, "fill_r31");
        drain();
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        n = 0;
        while (busy_b && n < 100) begin
            n++;
            we0 = (n == 20);
            wa0 = 3;
            wd0 = 32'h0000_0033;
            clr_req = (n == 5);
            if (n == 2) begin
                set_ra(31, 3);
                push(0, 32'd0, "clr_rd_busy_b");
                push(2, 32'd0, "clr_rd_busy_n");
                drain();
            end
            @(negedge clk);
            #1;
        end
        idle_inputs();
        check_eq("clr_busy_len", 32'(n), 32'd31);
        zero_model();
        @(negedge clk);
        set_ra(3, 3);
        push(0, 32'd0, "clr_r3_dropped");
        push(3, 32'd0, "clr_r3_dropped_n");
        drain();
        read_all("clr");

        // Reset in the middle of a clear
        fill(32'hA5A5_0000);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        n = 0;
        m = 0;
        while (busy_b && n < 200) begin
            n++;
            if (n > 10) m++;
            rst = (n == 10);
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        check_eq("midrst_busy_after", 32'(m), 32'd31);
        push(5, 32'd0, "midrst_busy_n_done");
        drain();
        zero_model();
        read_all("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the next-generation Otter core, replacing the fixed 32×32, 2-read/1-write file. Provides NRD asynchronous read ports, two prioritised write ports, optional same-cycle write-to-read bypass, and a hardwired-zero register 0. A built-in clear sequencer zeroes the array after reset or on request, and signals `busy` while clearing.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREGS, 32, register count, power of two, ≥4; AW = $clog2(NREGS)
- NRD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns pre-write array contents
- Single clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- we0  in  1  write enable, port 0
- wa0  in  AW  write address, port 0
- wd0  in  XLEN  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  AW  write address, port 1
- wd1  in  XLEN  write data, port 1
- ra  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
- rd  out  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
- clr_req  in  1  single-cycle pulse requesting a full array clear
- busy  out  1  clear sequencer active; writes ignored, reads return 0

## Operation
- States: IDLE, CLEAR. Counter `cnt` (AW bits) indexes the register being cleared.
- rst high at a clock edge: state ← CLEAR, cnt ← 1, no array write. Holds for as long as rst is high.
- CLEAR with rst low: reg[cnt] ← 0, cnt ← cnt+1. The edge that clears reg[NREGS-1] moves the state to IDLE. cnt wraps to 0 and is not used in IDLE.
- IDLE with clr_req=1: state ← CLEAR, cnt ← 1. clr_req during CLEAR is ignored and does not restart the count. rst mid-CLEAR restarts at cnt=1.
- Writes occur only in IDLE. The write target register is wa when we=1 and wa≠0.
- Both ports write the same nonzero address: port 1 data is stored.
- Writes to register 0 are discarded. Register 0 is never stored and always reads 0.
- Reads are combinational: rd_k = 0 if busy, or if ra_k = 0; otherwise reg[ra_k].
- Bypass (BYPASS=1, IDLE): if an enabled write targets ra_k≠0 in the same cycle, rd_k = that write data. Port 1 takes precedence over port 0.
- With BYPASS=0, rd_k returns the old value; the new value is visible from the cycle after the write edge.

## Timing
- busy = (state == CLEAR), registered. It is 1 from the first rst edge and stays 1 for exactly NREGS-1 cycles after rst falls.
- After clr_req is sampled in IDLE, busy is 1 from the next cycle for exactly NREGS-1 cycles.
- Reset value of outputs: busy=1, rd=0 for all ports.
- Write latency: 1 edge. Read latency: 0 cycles (asynchronous).
- No state other than the sequencer is reset. The array content is defined only by the clear sequence.

## Structure
- Package regfile_pkg: `rf_state_t` enum {IDLE, CLEAR} and a function computing AW from NREGS.
- Sub-module regfile_clr_seq contains the state machine and the counter. Outputs: busy, clr_we, clr_addr.
- regfile_mp instantiates regfile_clr_seq and holds:
  - the array, sized NREGS-1 with entry 0 omitted;
  - the write-priority mux;
  - NRD generated read/bypass muxes.

## Test plan
- Reset sequencing (NREGS=32): hold rst 3 cycles, then release. Required: busy=1 for exactly 31 cycles after release, then 0. All 32 registers read 0 immediately after.
- Dual write collision: we0=we1=1, wa0=wa1=5, wd0=0xAAAA_0000, wd1=0x1234_5678. Required: the next cycle reads reg5 = 0x1234_5678.
- x0 protection: write 0xFFFF_FFFF to address 0 on both ports. Required: ra=0 returns 0, both in the same cycle and afterward.
- Bypass: BYPASS=1, we0=1, wa0=7, wd0=0xDEAD_BEEF, ra0=7. Required: rd0=0xDEAD_BEEF in the same cycle. With BYPASS=0, the same stimulus gives the old value; 0xDEAD_BEEF appears next cycle.
- Runtime clear: fill regs 1..31 with their index, then pulse clr_req. Required: busy high for 31 cycles, and writes issued during busy are dropped (reg3 stays 0). After clearing, all reads are 0.
- Reset mid-clear: assert rst at clear cycle 10 for 1 cycle. Required: busy stays high for 31 further cycles, then all registers read 0.
